// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronized RXD sampled mid-bit, byte handed over on a valid/ready holding register.
// oVALID rises one cycle after the mid-stop sample; a byte completing while the register is full is dropped and flags overrun.
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iRXD,
  input  logic       iREADY,
  input  logic       iCLR_ERR,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFRAME_ERR,
  output logic       oOVERRUN,
  output logic       oBUSY
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   byte_done;
  logic                   frame_err;
  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   ovr_q;

  assign rxs = sync_q[SYNC_STAGES-1];

  // Loaded with idle level so a reset never looks like a start edge.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], iRXD};
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rxs;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= frame_err;
      if (byte_done && (!valid_q || iREADY)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && iREADY) begin
        valid_q <= 1'b0;
      end
      // A new overrun outranks a simultaneous clear.
      if (byte_done && valid_q && !iREADY) ovr_q <= 1'b1;
      else if (iCLR_ERR)                   ovr_q <= 1'b0;
    end
  end

  assign oDATA      = data_q;
  assign oVALID     = valid_q;
  assign oFRAME_ERR = ferr_q;
  assign oOVERRUN   = ovr_q;
  assign oBUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: frame-level scoreboard predicts each byte's completion cycle and the holding-register handshake.
// Directed frames cover reset, overrun, framing error/BREAK, glitch, mid-frame reset and a +2% baud stream.
module tb_uart_rx_8n1;
  localparam int CPB      = 16;
  localparam int SYNC     = 2;
  // First posedge seeing the start bit on iRXD -> edge on which the stop bit is judged.
  localparam int DONE_OFS = SYNC + CPB / 2 + 9 * CPB;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd   = 1'b1;
  logic       ready = 1'b0;
  logic       clr   = 1'b0;
  logic [7:0] dat;
  logic       vld, fe, ovr, busy;

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iRXD(rxd), .iREADY(ready), .iCLR_ERR(clr),
    .oDATA(dat), .oVALID(vld), .oFRAME_ERR(fe), .oOVERRUN(ovr), .oBUSY(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  ev_t        evq[$];
  ev_t        ev_now;
  int         cyc     = 0;
  int         n_vec   = 0;
  int         n_bad   = 0;
  int         fe_seen = 0;
  bit         chk_en  = 1'b0;
  bit         done, ovr_set;
  logic [7:0] m_dat;
  logic       m_vld, m_fe, m_ovr;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame as a waveform: bit k spans [k*T, (k+1)*T) with T = CPB*100/pct cycles.
  task automatic send(input logic [7:0] b, input bit stop_lvl, input int pct);
    ev_t        ev;
    logic [9:0] frame;
    frame  = {stop_lvl, b, 1'b0};
    ev.cyc = cyc + 1 + DONE_OFS;
    ev.b   = b;
    ev.ok  = stop_lvl;
    evq.push_back(ev);
    for (int k = 0; k < 10; k++) begin
      rxd = frame[k];
      repeat (((k + 1) * CPB * 100) / pct - (k * CPB * 100) / pct) @(negedge clk);
    end
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      done    = 1'b0;
      ovr_set = 1'b0;
      m_fe    = 1'b0;
      if (!rst_n) begin
        m_dat = 8'h00;
        m_vld = 1'b0;
        m_ovr = 1'b0;
        evq.delete();
      end else begin
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          ev_now = evq.pop_front();
          if (ev_now.ok) done = 1'b1;
          else           m_fe = 1'b1;
        end
        if (done && (!m_vld || ready)) begin
          m_dat = ev_now.b;
          m_vld = 1'b1;
        end else if (done) begin
          ovr_set = 1'b1;
        end else if (m_vld && ready) begin
          m_vld = 1'b0;
        end
        if (ovr_set)  m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
      end
      #1;
      if (chk_en) begin
        check("oVALID", 8'(vld), 8'(m_vld));
        check("oDATA", dat, m_dat);
        check("oFRAME_ERR", 8'(fe), 8'(m_fe));
        check("oOVERRUN", 8'(ovr), 8'(m_ovr));
      end
      if (fe === 1'b1) fe_seen++;
    end
  end

  initial begin
    // 1: reset held while the line toggles
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rxd = i[0];
      @(negedge clk);
      check("rst_busy", 8'(busy), 8'h00);
    end
    rxd = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", 8'(busy), 8'h00);
    check("post_rst_data", dat, 8'h00);

    // 2: single byte, then read it
    send(8'hA5, 1'b1, 100);
    repeat (4) @(negedge clk);
    check("a5_valid", 8'(vld), 8'h01);
    check("a5_data", dat, 8'hA5);
    check("a5_no_ferr", 8'(fe_seen), 8'h00);
    pulse_ready();
    check("a5_read_clears", 8'(vld), 8'h00);
    check("a5_data_kept", dat, 8'hA5);

    // 3: back-to-back with no reader -> overrun
    send(8'h31, 1'b1, 100);
    send(8'h32, 1'b1, 100);
    repeat (4) @(negedge clk);
    check("ovr_data_kept", dat, 8'h31);
    check("ovr_set", 8'(ovr), 8'h01);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovr_cleared", 8'(ovr), 8'h00);
    pulse_ready();

    // 4: framing error followed by BREAK
    fe_seen = 0;
    send(8'h55, 1'b0, 100);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    check("break_busy", 8'(busy), 8'h01);
    check("ferr_once", 8'(fe_seen), 8'h01);
    check("ferr_no_valid", 8'(vld), 8'h00);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    check("break_end_idle", 8'(busy), 8'h00);
    send(8'h0F, 1'b1, 100);
    repeat (4) @(negedge clk);
    check("0f_data", dat, 8'h0F);
    pulse_ready();

    // 5: short glitch on the idle line
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy", 8'(busy), 8'h01);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_idle", 8'(busy), 8'h00);
    check("glitch_no_valid", 8'(vld), 8'h00);
    check("glitch_no_ferr", 8'(fe_seen), 8'h01);

    // 6: reset after bit 3 of a partial frame, then a clean frame and a fast stream
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rxd = (k == 1 || k == 3);
      repeat (CPB) @(negedge clk);
    end
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_busy", 8'(busy), 8'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send(8'hC3, 1'b1, 100);
    repeat (4) @(negedge clk);
    check("c3_data", dat, 8'hC3);
    check("c3_valid", 8'(vld), 8'h01);
    ready = 1'b1;
    for (int b = 0; b < 256; b++) send(8'(b), 1'b1, 102);
    repeat (20) @(negedge clk);
    check("stream_last", dat, 8'hFF);
    check("stream_no_ovr", 8'(ovr), 8'h00);
    check("stream_no_ferr", 8'(fe_seen), 8'h01);
    check("stream_drained", 8'(evq.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
